// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: coin collection, priced selection with per-item
// stock, one-cycle vend pulse and greedy coin-by-coin change return.
module vending_machine_multi #(
  parameter int NUM_ITEMS  = 4,
  parameter int PRICE_BASE = 15,
  parameter int PRICE_STEP = 10,
  parameter int MAX_CREDIT = 95,
  parameter int MAX_STOCK  = 7,
  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  localparam int CR_W  = $clog2(MAX_CREDIT + 1),
  localparam int ST_W  = $clog2(MAX_STOCK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in,
  input  logic             sel_valid,
  input  logic [IDX_W-1:0] sel,
  input  logic             cancel,
  input  logic             restock_valid,
  input  logic [IDX_W-1:0] restock_item,
  output logic             out,
  output logic [IDX_W-1:0] out_item,
  output logic [1:0]       change,
  output logic [CR_W-1:0]  credit,
  output logic             coin_reject,
  output logic             insufficient,
  output logic             sold_out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t           state_reg, state_next;
  logic [CR_W-1:0]  credit_next;
  logic             out_next, coin_reject_next, insufficient_next, sold_out_next;
  logic [IDX_W-1:0] out_item_next;
  logic [1:0]       change_next;
  logic             dec_en;

  logic [CR_W:0]         coin_val, credit_sum;
  logic [CR_W-1:0]       sel_price, chg_amt;
  logic [1:0]            chg_code;
  logic                  coin_nz, sel_ok, sel_empty;
  logic [NUM_ITEMS-1:0]  stock_empty;

  always_comb begin
    case (in)
      2'b01:   coin_val = (CR_W+1)'(5);
      2'b10:   coin_val = (CR_W+1)'(10);
      2'b11:   coin_val = (CR_W+1)'(25);
      default: coin_val = '0;
    endcase
  end

  assign coin_nz    = (in != 2'b00);
  assign credit_sum = {1'b0, credit} + coin_val;
  assign sel_price  = CR_W'(PRICE_BASE + int'(sel) * PRICE_STEP);
  assign sel_ok     = (int'(sel) < NUM_ITEMS);
  assign sel_empty  = sel_ok ? stock_empty[sel] : 1'b1;

  // Greedy change: largest coin not exceeding the remaining credit.
  always_comb begin
    if (credit >= CR_W'(25)) begin
      chg_code = 2'b11;
      chg_amt  = CR_W'(25);
    end else if (credit >= CR_W'(10)) begin
      chg_code = 2'b10;
      chg_amt  = CR_W'(10);
    end else begin
      chg_code = 2'b01;
      chg_amt  = CR_W'(5);
    end
  end

  always_comb begin
    state_next        = state_reg;
    credit_next       = credit;
    out_next          = 1'b0;
    out_item_next     = '0;
    change_next       = 2'b00;
    coin_reject_next  = 1'b0;
    insufficient_next = 1'b0;
    sold_out_next     = 1'b0;
    dec_en            = 1'b0;
    case (state_reg)
      IDLE, COLLECT: begin
        if (cancel && state_reg == COLLECT && credit != '0) begin
          state_next       = CHANGE;
          coin_reject_next = coin_nz;
        end else if (sel_valid) begin
          coin_reject_next = coin_nz;
          if (sel_empty) begin
            sold_out_next = 1'b1;
          end else if (credit < sel_price) begin
            insufficient_next = 1'b1;
          end else begin
            state_next    = VEND;
            out_next      = 1'b1;
            out_item_next = sel;
            credit_next   = credit - sel_price;
            dec_en        = 1'b1;
          end
        end else if (coin_nz) begin
          if (credit_sum <= (CR_W+1)'(MAX_CREDIT)) begin
            credit_next = credit_sum[CR_W-1:0];
            state_next  = COLLECT;
          end else begin
            coin_reject_next = 1'b1;
          end
        end
      end
      VEND: begin
        coin_reject_next = coin_nz;
        state_next       = (credit != '0) ? CHANGE : IDLE;
      end
      default: begin
        coin_reject_next = coin_nz;
        if (credit == '0) begin
          state_next = IDLE;
        end else begin
          change_next = chg_code;
          credit_next = credit - chg_amt;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      credit       <= '0;
      out          <= 1'b0;
      out_item     <= '0;
      change       <= 2'b00;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      sold_out     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      credit       <= credit_next;
      out          <= out_next;
      out_item     <= out_item_next;
      change       <= change_next;
      coin_reject  <= coin_reject_next;
      insufficient <= insufficient_next;
      sold_out     <= sold_out_next;
      busy         <= (state_next == VEND) || (state_next == CHANGE);
    end
  end

  // Restock has priority over a simultaneous vend decrement of the same item.
  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_stock
    logic [ST_W-1:0] cnt_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg <= ST_W'(MAX_STOCK);
      end else if (restock_valid && restock_item == IDX_W'(gi)) begin
        cnt_reg <= ST_W'(MAX_STOCK);
      end else if (dec_en && sel == IDX_W'(gi) && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - ST_W'(1);
      end
    end
    assign stock_empty[gi] = (cnt_reg == '0);
  end

endmodule
